// File: rtl/ctr_pkg.sv
// Shared definitions for the contract-equivalence checker and its retire aligner:
// the per-instruction observation record and the instruction format constants.
package ctr_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] instr;
    logic [XLEN_DEFAULT-1:0] reg_rs1;
    logic [XLEN_DEFAULT-1:0] reg_rs2;
    logic [XLEN_DEFAULT-1:0] reg_rd;
    logic [XLEN_DEFAULT-1:0] mem_addr;
    logic [XLEN_DEFAULT-1:0] mem_r_data;
    logic [XLEN_DEFAULT-1:0] mem_w_data;
  } retire_obs_t;

  // Major opcodes the checker decodes to decide which observation fields are meaningful.
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_UNKNOWN
  } instr_fmt_e;

  function automatic instr_fmt_e fmt_of(input logic [XLEN_DEFAULT-1:0] instr);
    unique case (instr[6:0])
      OPC_OP:                fmt_of = FMT_R;
      OPC_LOAD, OPC_OP_IMM:  fmt_of = FMT_I;
      OPC_STORE:             fmt_of = FMT_S;
      OPC_BRANCH:            fmt_of = FMT_B;
      OPC_LUI:               fmt_of = FMT_U;
      OPC_JAL:               fmt_of = FMT_J;
      default:               fmt_of = FMT_UNKNOWN;
    endcase
  endfunction

endpackage

// File: rtl/retire_pair_aligner_if.sv
// Bundle between the two cores' retire taps (master) and the pair aligner (slave),
// including the aligned pair fields handed on to the checker.
interface retire_pair_aligner_if
  import ctr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = ctr_pkg::XLEN_DEFAULT
);

  localparam int CW = $clog2(DEPTH + 1);

  logic              valid_1_i;
  logic              valid_2_i;
  retire_obs_t       obs_1_i;
  retire_obs_t       obs_2_i;

  logic              stall_1_o;
  logic              stall_2_o;
  logic              retire_o;
  logic              overflow_o;
  logic [CW-1:0]     count_1_o;
  logic [CW-1:0]     count_2_o;

  logic [XLEN-1:0]   instr_1_o,      instr_2_o;
  logic [XLEN-1:0]   reg_rs1_1_o,    reg_rs1_2_o;
  logic [XLEN-1:0]   reg_rs2_1_o,    reg_rs2_2_o;
  logic [XLEN-1:0]   reg_rd_1_o,     reg_rd_2_o;
  logic [XLEN-1:0]   mem_addr_1_o,   mem_addr_2_o;
  logic [XLEN-1:0]   mem_r_data_1_o, mem_r_data_2_o;
  logic [XLEN-1:0]   mem_w_data_1_o, mem_w_data_2_o;

  modport master (
    output valid_1_i, valid_2_i, obs_1_i, obs_2_i,
    input  stall_1_o, stall_2_o, retire_o, overflow_o, count_1_o, count_2_o,
    input  instr_1_o, instr_2_o, reg_rs1_1_o, reg_rs1_2_o, reg_rs2_1_o, reg_rs2_2_o,
    input  reg_rd_1_o, reg_rd_2_o, mem_addr_1_o, mem_addr_2_o,
    input  mem_r_data_1_o, mem_r_data_2_o, mem_w_data_1_o, mem_w_data_2_o
  );

  modport slave (
    input  valid_1_i, valid_2_i, obs_1_i, obs_2_i,
    output stall_1_o, stall_2_o, retire_o, overflow_o, count_1_o, count_2_o,
    output instr_1_o, instr_2_o, reg_rs1_1_o, reg_rs1_2_o, reg_rs2_1_o, reg_rs2_2_o,
    output reg_rd_1_o, reg_rd_2_o, mem_addr_1_o, mem_addr_2_o,
    output mem_r_data_1_o, mem_r_data_2_o, mem_w_data_1_o, mem_w_data_2_o
  );

endinterface

// File: rtl/retire_pair_aligner_obs_fifo.sv
// Per-core observation FIFO. Full/empty come from the occupancy count, so the
// pointers can wrap freely; a push into a full FIFO is only accepted alongside a pop.
module obs_fifo
  import ctr_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = retire_obs_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  T                           wdata,
  output T                           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  T                mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            accept;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;
  assign rdata  = mem[rd_ptr];

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(accept) - CW'(pop);
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only read after being written.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/retire_pair_aligner.sv
// Buffers the two cores' retire streams and releases them pairwise, so the n-th
// retirement of core 1 always meets the n-th retirement of core 2.
module retire_pair_aligner
  import ctr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = ctr_pkg::XLEN_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  retire_pair_aligner_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic          pop;
  logic          empty_1, empty_2;
  logic          full_1,  full_2;
  logic          drop_1,  drop_2;
  logic [CW-1:0] count_1, count_2;
  retire_obs_t   head_1,  head_2;
  retire_obs_t   out_1_q, out_2_q;
  logic          retire_q;
  logic          overflow_q;

  // A pair leaves only when both cores have an entry waiting.
  assign pop = !empty_1 && !empty_2;

  obs_fifo #(.DEPTH(DEPTH), .T(retire_obs_t)) u_fifo_1 (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (bus.valid_1_i),
    .pop   (pop),
    .wdata (bus.obs_1_i),
    .rdata (head_1),
    .count (count_1),
    .full  (full_1),
    .empty (empty_1),
    .drop  (drop_1)
  );

  obs_fifo #(.DEPTH(DEPTH), .T(retire_obs_t)) u_fifo_2 (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (bus.valid_2_i),
    .pop   (pop),
    .wdata (bus.obs_2_i),
    .rdata (head_2),
    .count (count_2),
    .full  (full_2),
    .empty (empty_2),
    .drop  (drop_2)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      retire_q   <= 1'b0;
      overflow_q <= 1'b0;
      out_1_q    <= '0;
      out_2_q    <= '0;
    end else begin
      retire_q <= pop;
      if (pop) begin
        out_1_q <= head_1;
        out_2_q <= head_2;
      end
      if (drop_1 || drop_2) overflow_q <= 1'b1;
    end
  end

  assign bus.retire_o   = retire_q;
  assign bus.overflow_o = overflow_q;
  assign bus.stall_1_o  = full_1;
  assign bus.stall_2_o  = full_2;
  assign bus.count_1_o  = count_1;
  assign bus.count_2_o  = count_2;

  assign bus.instr_1_o      = out_1_q.instr;
  assign bus.reg_rs1_1_o    = out_1_q.reg_rs1;
  assign bus.reg_rs2_1_o    = out_1_q.reg_rs2;
  assign bus.reg_rd_1_o     = out_1_q.reg_rd;
  assign bus.mem_addr_1_o   = out_1_q.mem_addr;
  assign bus.mem_r_data_1_o = out_1_q.mem_r_data;
  assign bus.mem_w_data_1_o = out_1_q.mem_w_data;

  assign bus.instr_2_o      = out_2_q.instr;
  assign bus.reg_rs1_2_o    = out_2_q.reg_rs1;
  assign bus.reg_rs2_2_o    = out_2_q.reg_rs2;
  assign bus.reg_rd_2_o     = out_2_q.reg_rd;
  assign bus.mem_addr_2_o   = out_2_q.mem_addr;
  assign bus.mem_r_data_2_o = out_2_q.mem_r_data;
  assign bus.mem_w_data_2_o = out_2_q.mem_w_data;

endmodule
